// File: rtl/cv32e41p_trace_capture.sv
// rtl/cv32e41p_trace_capture.sv - pairs issued instructions with writebacks into in-order trace records
// Optional: define CV32E41P_TRACE_CAPTURE_TIMESTAMP_EN to stamp each record with its issue cycle.
module cv32e41p_trace_capture #(
  parameter int DEPTH = 4,
  parameter int SEQ_W = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     issue_valid_i,
  output logic                     issue_ready_o,
  input  logic [31:0]              issue_pc_i,
  input  logic [31:0]              issue_instr_i,
  input  logic                     issue_compressed_i,
  input  logic                     issue_rd_we_i,
  input  logic [4:0]               issue_rd_addr_i,
  input  logic                     wb_valid_i,
  input  logic [4:0]               wb_rd_addr_i,
  input  logic [31:0]              wb_rd_wdata_i,
  output logic                     rec_valid_o,
  input  logic                     rec_ready_i,
  output logic [31:0]              rec_pc_o,
  output logic [31:0]              rec_instr_o,
  output logic                     rec_compressed_o,
  output logic                     rec_rd_we_o,
  output logic [4:0]               rec_rd_addr_o,
  output logic [31:0]              rec_rd_wdata_o,
  output logic [2:0]               rec_class_o,
  output logic [SEQ_W-1:0]         rec_seq_o,
  output logic [31:0]              rec_time_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     err_mismatch_o,
  output logic                     err_orphan_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_AMO    = 7'b0101111;

  localparam logic [2:0] CLS_OTHER  = 3'd0;
  localparam logic [2:0] CLS_CTRL   = 3'd1;
  localparam logic [2:0] CLS_LOAD   = 3'd2;
  localparam logic [2:0] CLS_STORE  = 3'd3;
  localparam logic [2:0] CLS_SYSTEM = 3'd4;
  localparam logic [2:0] CLS_MULDIV = 3'd5;
  localparam logic [2:0] CLS_FENCE  = 3'd6;
  localparam logic [2:0] CLS_AMO    = 3'd7;

  function automatic logic [2:0] decode_class(input logic [31:0] instr);
    logic [2:0] cls;
    cls = CLS_OTHER;
    case (instr[6:0])
      OPC_JAL, OPC_JALR, OPC_BRANCH: cls = CLS_CTRL;
      OPC_LOAD:   cls = CLS_LOAD;
      OPC_STORE:  cls = CLS_STORE;
      OPC_SYSTEM: cls = CLS_SYSTEM;
      OPC_OP:     cls = (instr[31:25] == 7'b0000001) ? CLS_MULDIV : CLS_OTHER;
      OPC_FENCE:  cls = CLS_FENCE;
      OPC_AMO:    cls = CLS_AMO;
      default:    cls = CLS_OTHER;
    endcase
    return cls;
  endfunction

  // Pending-record storage, indexed as a circular buffer
  logic        valid_q   [DEPTH];
  logic        valid_d   [DEPTH];
  logic [31:0] pc_q      [DEPTH];
  logic [31:0] pc_d      [DEPTH];
  logic [31:0] instr_q   [DEPTH];
  logic [31:0] instr_d   [DEPTH];
  logic        comp_q    [DEPTH];
  logic        comp_d    [DEPTH];
  logic        rd_we_q   [DEPTH];
  logic        rd_we_d   [DEPTH];
  logic [4:0]  rd_addr_q [DEPTH];
  logic [4:0]  rd_addr_d [DEPTH];
  logic        done_q    [DEPTH];
  logic        done_d    [DEPTH];
  logic [31:0] wdata_q   [DEPTH];
  logic [31:0] wdata_d   [DEPTH];
  logic [2:0]  class_q   [DEPTH];
  logic [2:0]  class_d   [DEPTH];

  logic [PW-1:0]    head_q, head_d;
  logic [PW-1:0]    tail_q, tail_d;
  logic [CW-1:0]    count_q, count_d;
  logic [SEQ_W-1:0] seq_q, seq_d;
  logic             err_mismatch_q, err_mismatch_d;
  logic             err_orphan_q, err_orphan_d;

  logic          rec_valid;
  logic          push;
  logic          pop;
  logic          issue_rd_we_eff;
  logic          wb_take;
  logic          match_found;
  logic [PW-1:0] match_idx;
  logic [PW-1:0] scan_idx;

`ifdef CV32E41P_TRACE_CAPTURE_TIMESTAMP_EN
  logic [31:0] time_q, time_d;
  logic [31:0] ts_q [DEPTH];
  logic [31:0] ts_d [DEPTH];
`endif

  assign issue_ready_o   = (count_q < DEPTH_C);
  assign rec_valid       = valid_q[head_q] && (!rd_we_q[head_q] || done_q[head_q]);
  assign push            = issue_valid_i && issue_ready_o;
  assign pop             = rec_valid && rec_ready_i;
  assign issue_rd_we_eff = issue_rd_we_i && (issue_rd_addr_i != 5'd0);
  assign wb_take         = wb_valid_i && (wb_rd_addr_i != 5'd0);

  // Find the oldest entry still waiting for its writeback (registered state only)
  always_comb begin
    match_found = 1'b0;
    match_idx   = '0;
    scan_idx    = '0;
    for (int i = 0; i < DEPTH; i++) begin
      scan_idx = head_q + PW'(i);
      if (!match_found && valid_q[scan_idx] && rd_we_q[scan_idx] && !done_q[scan_idx]) begin
        match_found = 1'b1;
        match_idx   = scan_idx;
      end
    end
  end

  // Next state: writeback completion, head pop, tail push, error flags
  always_comb begin
    valid_d        = valid_q;
    pc_d           = pc_q;
    instr_d        = instr_q;
    comp_d         = comp_q;
    rd_we_d        = rd_we_q;
    rd_addr_d      = rd_addr_q;
    done_d         = done_q;
    wdata_d        = wdata_q;
    class_d        = class_q;
    head_d         = head_q;
    tail_d         = tail_q;
    seq_d          = seq_q;
    err_mismatch_d = err_mismatch_q;
    err_orphan_d   = err_orphan_q;
`ifdef CV32E41P_TRACE_CAPTURE_TIMESTAMP_EN
    ts_d           = ts_q;
    time_d         = time_q + 32'd1;
`endif

    if (wb_take) begin
      if (match_found) begin
        done_d[match_idx]  = 1'b1;
        wdata_d[match_idx] = wb_rd_wdata_i;
        if (wb_rd_addr_i != rd_addr_q[match_idx]) begin
          err_mismatch_d = 1'b1;
        end
      end else begin
        err_orphan_d = 1'b1;
      end
    end

    if (pop) begin
      valid_d[head_q] = 1'b0;
      head_d          = head_q + PW'(1);
      seq_d           = seq_q + SEQ_W'(1);
    end

    // The tail slot is never the popped head or the match target: it is invalid
    if (push) begin
      valid_d[tail_q]   = 1'b1;
      pc_d[tail_q]      = issue_pc_i;
      instr_d[tail_q]   = issue_instr_i;
      comp_d[tail_q]    = issue_compressed_i;
      rd_we_d[tail_q]   = issue_rd_we_eff;
      rd_addr_d[tail_q] = issue_rd_addr_i;
      done_d[tail_q]    = 1'b0;
      wdata_d[tail_q]   = 32'd0;
      class_d[tail_q]   = decode_class(issue_instr_i);
`ifdef CV32E41P_TRACE_CAPTURE_TIMESTAMP_EN
      ts_d[tail_q]      = time_q;
`endif
      tail_d            = tail_q + PW'(1);
    end

    count_d = count_q + CW'(push) - CW'(pop);
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head_q         <= '0;
      tail_q         <= '0;
      count_q        <= '0;
      seq_q          <= '0;
      err_mismatch_q <= 1'b0;
      err_orphan_q   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        valid_q[i]   <= 1'b0;
        pc_q[i]      <= '0;
        instr_q[i]   <= '0;
        comp_q[i]    <= 1'b0;
        rd_we_q[i]   <= 1'b0;
        rd_addr_q[i] <= '0;
        done_q[i]    <= 1'b0;
        wdata_q[i]   <= '0;
        class_q[i]   <= '0;
      end
    end else begin
      head_q         <= head_d;
      tail_q         <= tail_d;
      count_q        <= count_d;
      seq_q          <= seq_d;
      err_mismatch_q <= err_mismatch_d;
      err_orphan_q   <= err_orphan_d;
      valid_q        <= valid_d;
      pc_q           <= pc_d;
      instr_q        <= instr_d;
      comp_q         <= comp_d;
      rd_we_q        <= rd_we_d;
      rd_addr_q      <= rd_addr_d;
      done_q         <= done_d;
      wdata_q        <= wdata_d;
      class_q        <= class_d;
    end
  end

`ifdef CV32E41P_TRACE_CAPTURE_TIMESTAMP_EN
  // Free-running cycle counter and per-entry issue stamps
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      time_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        ts_q[i] <= '0;
      end
    end else begin
      time_q <= time_d;
      ts_q   <= ts_d;
    end
  end

  assign rec_time_o = rec_valid ? ts_q[head_q] : 32'd0;
`else
  assign rec_time_o = 32'd0;
`endif

  // Record fields read as zero whenever no record is presented
  assign rec_valid_o      = rec_valid;
  assign rec_pc_o         = rec_valid ? pc_q[head_q]      : 32'd0;
  assign rec_instr_o      = rec_valid ? instr_q[head_q]   : 32'd0;
  assign rec_compressed_o = rec_valid ? comp_q[head_q]    : 1'b0;
  assign rec_rd_we_o      = rec_valid ? rd_we_q[head_q]   : 1'b0;
  assign rec_rd_addr_o    = rec_valid ? rd_addr_q[head_q] : 5'd0;
  assign rec_rd_wdata_o   = rec_valid ? wdata_q[head_q]   : 32'd0;
  assign rec_class_o      = rec_valid ? class_q[head_q]   : 3'd0;
  assign rec_seq_o        = seq_q;
  assign count_o          = count_q;
  assign err_mismatch_o   = err_mismatch_q;
  assign err_orphan_o     = err_orphan_q;

endmodule

// File: tb/tb_cv32e41p_trace_capture.sv
// tb/tb_cv32e41p_trace_capture.sv - scoreboard bench for cv32e41p_trace_capture
module tb_cv32e41p_trace_capture;

  localparam int DEPTH = 4;
  localparam int SEQ_W = 16;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic             clk;
  logic             rst_n;
  logic             issue_valid_i;
  logic             issue_ready_o;
  logic [31:0]      issue_pc_i;
  logic [31:0]      issue_instr_i;
  logic             issue_compressed_i;
  logic             issue_rd_we_i;
  logic [4:0]       issue_rd_addr_i;
  logic             wb_valid_i;
  logic [4:0]       wb_rd_addr_i;
  logic [31:0]      wb_rd_wdata_i;
  logic             rec_valid_o;
  logic             rec_ready_i;
  logic [31:0]      rec_pc_o;
  logic [31:0]      rec_instr_o;
  logic             rec_compressed_o;
  logic             rec_rd_we_o;
  logic [4:0]       rec_rd_addr_o;
  logic [31:0]      rec_rd_wdata_o;
  logic [2:0]       rec_class_o;
  logic [SEQ_W-1:0] rec_seq_o;
  logic [31:0]      rec_time_o;
  logic [CW-1:0]    count_o;
  logic             err_mismatch_o;
  logic             err_orphan_o;

  cv32e41p_trace_capture #(.DEPTH(DEPTH), .SEQ_W(SEQ_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .issue_valid_i(issue_valid_i), .issue_ready_o(issue_ready_o),
    .issue_pc_i(issue_pc_i), .issue_instr_i(issue_instr_i),
    .issue_compressed_i(issue_compressed_i), .issue_rd_we_i(issue_rd_we_i),
    .issue_rd_addr_i(issue_rd_addr_i),
    .wb_valid_i(wb_valid_i), .wb_rd_addr_i(wb_rd_addr_i), .wb_rd_wdata_i(wb_rd_wdata_i),
    .rec_valid_o(rec_valid_o), .rec_ready_i(rec_ready_i),
    .rec_pc_o(rec_pc_o), .rec_instr_o(rec_instr_o), .rec_compressed_o(rec_compressed_o),
    .rec_rd_we_o(rec_rd_we_o), .rec_rd_addr_o(rec_rd_addr_o), .rec_rd_wdata_o(rec_rd_wdata_o),
    .rec_class_o(rec_class_o), .rec_seq_o(rec_seq_o), .rec_time_o(rec_time_o),
    .count_o(count_o), .err_mismatch_o(err_mismatch_o), .err_orphan_o(err_orphan_o)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        comp;
    logic        rd_we;
    logic [4:0]  rd;
    logic        done;
    logic [31:0] wdata;
    logic [2:0]  cls;
    logic [31:0] ts;
  } ent_t;

  ent_t        mq[$];
  int          seq_m;
  bit          orph_m;
  bit          mis_m;
  int unsigned cyc_m;
  int          checks;
  int          failures;

  logic [6:0] ops [10] = '{7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h73, 7'h33, 7'h0F, 7'h2F, 7'h13};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
    end
  endtask

  function automatic logic [2:0] ref_class(input logic [31:0] w);
    logic [6:0] op;
    op = w[6:0];
    if (op == 7'h6F || op == 7'h67 || op == 7'h63) return 3'd1;
    if (op == 7'h03) return 3'd2;
    if (op == 7'h23) return 3'd3;
    if (op == 7'h73) return 3'd4;
    if (op == 7'h33 && w[31:25] == 7'h01) return 3'd5;
    if (op == 7'h0F) return 3'd6;
    if (op == 7'h2F) return 3'd7;
    return 3'd0;
  endfunction

  function automatic bit head_complete();
    if (mq.size() == 0) return 1'b0;
    return !mq[0].rd_we || mq[0].done;
  endfunction

  // Reference model: applies the inputs seen at each clock edge to a queue of pending records
  always @(posedge clk) begin
    bit   pop;
    bit   push;
    int   k;
    ent_t e;
    if (!rst_n) begin
      mq.delete();
      seq_m  = 0;
      orph_m = 1'b0;
      mis_m  = 1'b0;
      cyc_m  = 0;
    end else begin
      pop  = head_complete() && rec_ready_i;
      push = issue_valid_i && (mq.size() < DEPTH);
      if (wb_valid_i && wb_rd_addr_i != 5'd0) begin
        k = -1;
        for (int i = 0; i < mq.size(); i++)
          if (k < 0 && mq[i].rd_we && !mq[i].done) k = i;
        if (k < 0) orph_m = 1'b1;
        else begin
          mq[k].done  = 1'b1;
          mq[k].wdata = wb_rd_wdata_i;
          if (mq[k].rd != wb_rd_addr_i) mis_m = 1'b1;
        end
      end
      if (pop) begin
        void'(mq.pop_front());
        seq_m = (seq_m + 1) % (1 << SEQ_W);
      end
      if (push) begin
        e.pc    = issue_pc_i;
        e.instr = issue_instr_i;
        e.comp  = issue_compressed_i;
        e.rd_we = issue_rd_we_i && (issue_rd_addr_i != 5'd0);
        e.rd    = issue_rd_addr_i;
        e.done  = 1'b0;
        e.wdata = 32'd0;
        e.cls   = ref_class(issue_instr_i);
        e.ts    = cyc_m;
        mq.push_back(e);
      end
      cyc_m++;
    end
  end

  // Monitor: compares presented state and head record against the model on the falling edge
  always @(negedge clk) begin
    bit ev;
    if (rst_n) begin
      ev = head_complete();
      chk("rec_valid", rec_valid_o, ev);
      chk("issue_ready", issue_ready_o, mq.size() < DEPTH);
      chk("count", count_o, mq.size());
      chk("err_orphan", err_orphan_o, orph_m);
      chk("err_mismatch", err_mismatch_o, mis_m);
      if (ev && rec_valid_o) begin
        chk("rec_pc", rec_pc_o, mq[0].pc);
        chk("rec_instr", rec_instr_o, mq[0].instr);
        chk("rec_compressed", rec_compressed_o, mq[0].comp);
        chk("rec_rd_we", rec_rd_we_o, mq[0].rd_we);
        chk("rec_rd_addr", rec_rd_addr_o, mq[0].rd);
        chk("rec_rd_wdata", rec_rd_wdata_o, mq[0].rd_we ? mq[0].wdata : 32'd0);
        chk("rec_class", rec_class_o, mq[0].cls);
        chk("rec_seq", rec_seq_o, seq_m);
`ifdef CV32E41P_TRACE_CAPTURE_TIMESTAMP_EN
        chk("rec_time", rec_time_o, mq[0].ts);
`else
        chk("rec_time", rec_time_o, 32'd0);
`endif
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic idle();
    issue_valid_i = 1'b0;
    wb_valid_i    = 1'b0;
  endtask

  task automatic set_issue(input logic [31:0] pc, input logic [31:0] instr,
                           input logic we, input logic [4:0] rd);
    issue_valid_i      = 1'b1;
    issue_pc_i         = pc;
    issue_instr_i      = instr;
    issue_compressed_i = 1'b0;
    issue_rd_we_i      = we;
    issue_rd_addr_i    = rd;
  endtask

  task automatic set_wb(input logic [4:0] rd, input logic [31:0] d);
    wb_valid_i    = 1'b1;
    wb_rd_addr_i  = rd;
    wb_rd_wdata_i = d;
  endtask

  initial begin
    logic [31:0] w;
    int          cand;
    checks             = 0;
    failures           = 0;
    rst_n              = 1'b0;
    rec_ready_i        = 1'b0;
    issue_pc_i         = '0;
    issue_instr_i      = '0;
    issue_compressed_i = 1'b0;
    issue_rd_we_i      = 1'b0;
    issue_rd_addr_i    = '0;
    wb_rd_addr_i       = '0;
    wb_rd_wdata_i      = '0;
    idle();
    tick(3);
    rst_n = 1'b1;

    chk("reset_rec_valid", rec_valid_o, 1'b0);
    chk("reset_issue_ready", issue_ready_o, 1'b1);
    chk("reset_count", count_o, 0);
    chk("reset_rec_pc", rec_pc_o, 32'd0);
    chk("reset_rec_wdata", rec_rd_wdata_o, 32'd0);
    chk("reset_rec_seq", rec_seq_o, 0);
    chk("reset_rec_time", rec_time_o, 32'd0);
    chk("reset_errs", {err_orphan_o, err_mismatch_o}, 2'b00);

    // ADDI x5 waits for its writeback
    set_issue(32'h80, 32'h00100293, 1'b1, 5'd5);
    tick(); idle(); tick(2);
    chk("addi_wait", rec_valid_o, 1'b0);
    set_wb(5'd5, 32'h1234);
    tick(); idle();
    chk("addi_valid", rec_valid_o, 1'b1);
    chk("addi_wdata", rec_rd_wdata_o, 32'h1234);
    chk("addi_class", rec_class_o, 3'd0);
    chk("addi_seq", rec_seq_o, 0);
    rec_ready_i = 1'b1;
    tick();

    // BEQ without writeback appears one cycle after issue
    set_issue(32'h84, 32'h00000063, 1'b0, 5'd0);
    tick(); idle();
    chk("beq_valid", rec_valid_o, 1'b1);
    chk("beq_class", rec_class_o, 3'd1);
    chk("beq_wdata", rec_rd_wdata_o, 32'd0);
    chk("beq_seq", rec_seq_o, 1);
    tick();

    // LW x6 then ADD x7 with delayed in-order writebacks
    set_issue(32'h88, 32'h00002303, 1'b1, 5'd6);
    tick();
    set_issue(32'h8C, 32'h000003B3, 1'b1, 5'd7);
    tick(); idle(); tick();
    set_wb(5'd6, 32'hA6);
    tick();
    set_wb(5'd7, 32'hA7);
    tick(); idle(); tick(3);

    // Fill to DEPTH with the tracer stalled
    rec_ready_i = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      set_issue(32'h100 + 4 * i, 32'h00000063, 1'b0, 5'd0);
      tick();
    end
    set_issue(32'h200, 32'h00000063, 1'b0, 5'd0);
    tick(); idle();
    chk("full_ready", issue_ready_o, 1'b0);
    chk("full_count", count_o, DEPTH);
    rec_ready_i = 1'b1;
    tick();
    rec_ready_i = 1'b0;
    chk("after_pop_ready", issue_ready_o, 1'b1);
    chk("after_pop_count", count_o, DEPTH - 1);
    rec_ready_i = 1'b1;
    tick(5);

    // Orphan and mismatched writebacks
    set_wb(5'd9, 32'h99);
    tick(); idle();
    chk("orphan_flag", err_orphan_o, 1'b1);
    set_issue(32'h300, 32'h00100193, 1'b1, 5'd3);
    tick(); idle();
    set_wb(5'd0, 32'h55);
    tick();
    set_wb(5'd4, 32'hDEAD);
    tick(); idle();
    chk("mismatch_flag", err_mismatch_o, 1'b1);
    chk("mismatch_valid", rec_valid_o, 1'b1);
    chk("mismatch_wdata", rec_rd_wdata_o, 32'hDEAD);
    tick(2);

    // Timestamp: issue at cycle 10 after reset, read at cycle 20
    rst_n = 1'b0;
    rec_ready_i = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(10);
    set_issue(32'h400, 32'h0000000F, 1'b0, 5'd0);
    tick(); idle(); tick(9);
`ifdef CV32E41P_TRACE_CAPTURE_TIMESTAMP_EN
    chk("timestamp", rec_time_o, 32'd10);
`else
    chk("timestamp", rec_time_o, 32'd0);
`endif
    chk("fence_class", rec_class_o, 3'd6);
    rec_ready_i = 1'b1;
    tick(2);

    // Randomized traffic with one mid-operation reset
    for (int n = 0; n < 1500; n++) begin
      if (n == 700) begin
        rst_n = 1'b0;
        idle();
        tick();
        rst_n = 1'b1;
      end
      w = $urandom;
      w[6:0] = ops[$urandom_range(0, 9)];
      if (w[6:0] == 7'h33 && $urandom_range(0, 1) == 1) w[31:25] = 7'h01;
      issue_valid_i      = ($urandom_range(0, 99) < 50);
      issue_pc_i         = $urandom;
      issue_instr_i      = w;
      issue_compressed_i = $urandom_range(0, 1) == 1;
      issue_rd_we_i      = $urandom_range(0, 3) != 0;
      issue_rd_addr_i    = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      cand = -1;
      for (int i = 0; i < mq.size(); i++)
        if (cand < 0 && mq[i].rd_we && !mq[i].done) cand = i;
      wb_valid_i    = 1'b0;
      wb_rd_wdata_i = $urandom;
      if (cand >= 0 && $urandom_range(0, 2) == 0) begin
        wb_valid_i   = 1'b1;
        wb_rd_addr_i = ($urandom_range(0, 19) == 0) ? 5'($urandom_range(1, 31)) : mq[cand].rd;
        if ($urandom_range(0, 24) == 0) wb_rd_addr_i = 5'd0;
      end else if (cand < 0 && $urandom_range(0, 39) == 0) begin
        wb_valid_i   = 1'b1;
        wb_rd_addr_i = 5'($urandom_range(0, 31));
      end
      rec_ready_i = $urandom_range(0, 3) != 0;
      tick();
    end
    idle();
    rec_ready_i = 1'b1;
    tick(10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
